// File: rtl/aes_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_spi_pkg
//  Description : Shared types and constants for the AES accelerator SPI host.
//                Holds the host FSM state encoding, the direction byte codes
//                and the frame length helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_spi_pkg;

   // Host FSM states (explicit 2-bit encoding)
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2,
      READ = 2'd3
   } state_t;

   // Direction byte values; the accelerator only looks at bit 0
   localparam logic [7:0] DIR_ENCRYPT = 8'h00;
   localparam logic [7:0] DIR_DECRYPT = 8'h01;

   // Load frame length: 8 direction bits + K key bits + 128 block bits
   function automatic int load_bits(input int k);
      return 136 + k;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_spi_clkgen.sv
`default_nettype none
// ============================================================================
//  Module      : aes_spi_clkgen
//  Description : SPI clock divider. While enabled, SCLK is low for CLK_DIV
//                clk cycles then high for CLK_DIV cycles. rise/fall are
//                combinational strobes that are high during the cycle whose
//                closing clk edge will raise/lower SCLK. When disabled the
//                divider is cleared and SCLK parks low.
//  Ports       : clk, reset (async, active-low), en  -> sclk, rise, fall
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_spi_clkgen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);

   if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("aes_spi_clkgen: CLK_DIV must be >= 1");
   end

   logic [c_CNT_W-1:0] r_cnt;
   logic               r_sclk;
   logic               w_tick;

   assign w_tick = en && (r_cnt == c_CNT_LAST);
   assign rise   = w_tick && !r_sclk;
   assign fall   = w_tick && r_sclk;
   assign sclk   = r_sclk;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
      end else if (!en) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
      end else begin
         r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
         if (w_tick) begin
            r_sclk <= !r_sclk;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/aes_spi_host.sv
`default_nettype none
// ============================================================================
//  Module      : aes_spi_host
//  Description : SPI master for the AES accelerator. Serialises
//                {dir, key, din} MSB first with spi_ce high, waits for the
//                accelerator's done, then clocks the 128-bit result back over
//                MISO and presents it on dout with a one-cycle dout_valid.
//  Ports       : clk, reset (async, active-low)
//                start/dir/key/din/ready   - parallel request handshake
//                dout/dout_valid           - parallel result
//                spi_sclk/spi_mosi/spi_ce/spi_miso, acc_done - accelerator side
//                err                       - watchdog flag (optional build)
//  Options     : define AES_SPI_HOST_TIMEOUT_EN to add the WAIT watchdog and
//                the err output.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_spi_host
   import aes_spi_pkg::*;
#(
   parameter int K              = 192,
   parameter int CLK_DIV        = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [7:0]     dir,
   input  logic [K-1:0]   key,
   input  logic [127:0]   din,
   output logic           ready,
   output logic [127:0]   dout,
   output logic           dout_valid,
   output logic           spi_sclk,
   output logic           spi_mosi,
   output logic           spi_ce,
   input  logic           spi_miso,
   input  logic           acc_done
`ifdef AES_SPI_HOST_TIMEOUT_EN
   ,
   output logic           err
`endif
);

   localparam int c_LOAD_BITS = load_bits(K);
   localparam int c_CNT_W     = $clog2(c_LOAD_BITS + 1);
`ifdef AES_SPI_HOST_TIMEOUT_EN
   localparam int c_WAIT_MAX  = TIMEOUT_CYCLES;
`else
   localparam int c_WAIT_MAX  = 2;
`endif
   localparam int c_WAIT_W    = $clog2(c_WAIT_MAX + 1);

   if (!(K == 128 || K == 192 || K == 256)) begin : g_bad_key_len
      $error("aes_spi_host: K must be 128, 192 or 256");
   end
   // done is ignored for the first two WAIT cycles, so a shorter watchdog
   // could never let done win
   if (TIMEOUT_CYCLES < 3) begin : g_bad_timeout
      $error("aes_spi_host: TIMEOUT_CYCLES must be >= 3");
   end

   state_t                 r_state, w_state_next;
   logic [c_LOAD_BITS-1:0] r_shift;
   logic [c_CNT_W-1:0]     r_bit_cnt;
   logic [c_WAIT_W-1:0]    r_wait_cnt;
   logic                   r_done_s1, r_done_s2;
   logic [126:0]           r_rx;
   logic [127:0]           r_dout;
   logic                   r_dout_valid;
   logic                   w_rise, w_fall, w_sclk_en;
   logic                   w_accept, w_load_fall, w_load_last;
   logic                   w_read_rise, w_read_last, w_done_ok;

   aes_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk  (clk),
      .reset(reset),
      .en   (w_sclk_en),
      .sclk (spi_sclk),
      .rise (w_rise),
      .fall (w_fall)
   );

   assign w_sclk_en   = (r_state == LOAD) || (r_state == READ);
   assign w_accept    = (r_state == IDLE) && start;
   // MOSI advances on each SCLK fall; the LOAD_BITS-th fall ends the frame
   assign w_load_fall = (r_state == LOAD) && w_fall;
   assign w_load_last = w_load_fall && (r_bit_cnt == c_CNT_W'(c_LOAD_BITS - 1));
   // MISO is sampled on the edge that raises SCLK; the trailing cycle of READ
   // (dout_valid high) must not take another sample
   assign w_read_rise = (r_state == READ) && w_rise && !r_dout_valid;
   assign w_read_last = w_read_rise && (r_bit_cnt == c_CNT_W'(127));
   assign w_done_ok   = (r_state == WAIT) && r_done_s2 && (r_wait_cnt >= c_WAIT_W'(2));

`ifdef AES_SPI_HOST_TIMEOUT_EN
   logic w_timeout;
   logic r_err;

   assign w_timeout = (r_state == WAIT) && !w_done_ok &&
                      (r_wait_cnt == c_WAIT_W'(TIMEOUT_CYCLES - 1));
   assign err       = r_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= 1'b0;
      end else if (w_timeout) begin
         r_err <= 1'b1;
      end
   end
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: if (start) w_state_next = LOAD;
         LOAD: if (w_load_last) w_state_next = WAIT;
         WAIT: begin
            if (w_done_ok) begin
               w_state_next = READ;
            end
`ifdef AES_SPI_HOST_TIMEOUT_EN
            else if (w_timeout) begin
               w_state_next = IDLE;
            end
`endif
         end
         READ: if (r_dout_valid) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      ready    = 1'b0;
      spi_ce   = 1'b0;
      spi_mosi = 1'b0;
      case (r_state)
         IDLE: ready = 1'b1;
         LOAD: begin
            spi_ce   = 1'b1;
            spi_mosi = r_shift[c_LOAD_BITS-1];
         end
         default: ;
      endcase
   end

   // Datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_wait_cnt   <= '0;
         r_done_s1    <= 1'b0;
         r_done_s2    <= 1'b0;
         r_rx         <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
      end else begin
         r_done_s1    <= acc_done;
         r_done_s2    <= r_done_s1;
         r_dout_valid <= w_read_last;

         if (w_accept) begin
            r_shift <= {dir, key, din};
         end else if (w_load_fall) begin
            r_shift <= {r_shift[c_LOAD_BITS-2:0], 1'b0};
         end

         if (w_accept || w_load_last) begin
            r_bit_cnt <= '0;
         end else if (w_load_fall || w_read_rise) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end

         if (r_state != WAIT) begin
            r_wait_cnt <= '0;
         end else if (r_wait_cnt != c_WAIT_W'(c_WAIT_MAX)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end

         if (w_read_rise) begin
            r_rx <= {r_rx[125:0], spi_miso};
         end
         if (w_read_last) begin
            r_dout <= {r_rx, spi_miso};
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;

endmodule
`default_nettype wire

// File: tb/tb_aes_spi_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_spi_host
//  Description : Self-checking bench for aes_spi_host. Two instances:
//                dut_a (K=192, CLK_DIV=4, TIMEOUT_CYCLES=16) and
//                dut_b (K=128, CLK_DIV=1), each with a behavioural SPI slave
//                that captures MOSI on SCLK rise during spi_ce and returns a
//                fixed 128-bit response MSB first during READ.
//  Options     : define AES_SPI_HOST_TIMEOUT_EN to also exercise the watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_spi_host;
   import aes_spi_pkg::*;

   localparam int KA = 192;
   localparam int DA = 4;
   localparam int LA = 328;
   localparam int KB = 128;
   localparam int DB = 1;
   localparam int LB = 264;

   localparam logic [191:0] KEY192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] RESP2  = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] A5     = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;
   localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] DINB   = 128'h3243f6a8885a308d313198a2e0370734;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // ---------------- dut_a ----------------
   logic           start_a = 1'b0;
   logic [7:0]     dir_a   = 8'h00;
   logic [KA-1:0]  key_a   = '0;
   logic [127:0]   din_a   = '0;
   logic           done_a  = 1'b0;
   logic [127:0]   resp_a  = '0;
   logic           ready_a, dv_a, sclk_a, mosi_a, ce_a, miso_a;
   logic [127:0]   dout_a;
`ifdef AES_SPI_HOST_TIMEOUT_EN
   logic           err_a;
`endif

   aes_spi_host #(.K(KA), .CLK_DIV(DA), .TIMEOUT_CYCLES(16)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .dir(dir_a), .key(key_a),
      .din(din_a), .ready(ready_a), .dout(dout_a), .dout_valid(dv_a),
      .spi_sclk(sclk_a), .spi_mosi(mosi_a), .spi_ce(ce_a), .spi_miso(miso_a),
      .acc_done(done_a)
`ifdef AES_SPI_HOST_TIMEOUT_EN
      , .err(err_a)
`endif
   );

   // ---------------- dut_b ----------------
   logic           start_b = 1'b0;
   logic [7:0]     dir_b   = 8'h00;
   logic [KB-1:0]  key_b   = '0;
   logic [127:0]   din_b   = '0;
   logic           done_b  = 1'b0;
   logic [127:0]   resp_b  = '0;
   logic           ready_b, dv_b, sclk_b, mosi_b, ce_b, miso_b;
   logic [127:0]   dout_b;
`ifdef AES_SPI_HOST_TIMEOUT_EN
   logic           err_b;
`endif

   aes_spi_host #(.K(KB), .CLK_DIV(DB)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .dir(dir_b), .key(key_b),
      .din(din_b), .ready(ready_b), .dout(dout_b), .dout_valid(dv_b),
      .spi_sclk(sclk_b), .spi_mosi(mosi_b), .spi_ce(ce_b), .spi_miso(miso_b),
      .acc_done(done_b)
`ifdef AES_SPI_HOST_TIMEOUT_EN
      , .err(err_b)
`endif
   );

   // ---------------- behavioural slaves ----------------
   logic [383:0] cap_a = '0;
   int           ncap_a = 0;
   logic [7:0]   rdn_a = '0;
   int           nframe_a = 0;
   int           nvalid_a = 0;

   always @(posedge sclk_a) begin
      if (ce_a) begin
         cap_a  <= {cap_a[382:0], mosi_a};
         ncap_a <= ncap_a + 1;
         rdn_a  <= '0;
      end else if (rdn_a != 8'd128) begin
         rdn_a <= rdn_a + 8'd1;
      end
   end
   assign miso_a = (rdn_a < 8'd128) ? resp_a[7'(8'd127 - rdn_a)] : 1'b0;
   always @(posedge ce_a) nframe_a <= nframe_a + 1;
   always @(negedge clk) if (dv_a === 1'b1) nvalid_a <= nvalid_a + 1;

   logic [383:0] cap_b = '0;
   int           ncap_b = 0;
   logic [7:0]   rdn_b = '0;
   int           nvalid_b = 0;

   always @(posedge sclk_b) begin
      if (ce_b) begin
         cap_b  <= {cap_b[382:0], mosi_b};
         ncap_b <= ncap_b + 1;
         rdn_b  <= '0;
      end else if (rdn_b != 8'd128) begin
         rdn_b <= rdn_b + 8'd1;
      end
   end
   assign miso_b = (rdn_b < 8'd128) ? resp_b[7'(8'd127 - rdn_b)] : 1'b0;
   always @(negedge clk) if (dv_b === 1'b1) nvalid_b <= nvalid_b + 1;

   // ---------------- stimulus helpers ----------------
   task automatic pulse_start_a(output int t0);
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_ce_fall_a(output int t, output bit ok);
      ok = 1'b0;
      t  = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (ce_a === 1'b0) begin
            ok = 1'b1;
            t  = cyc;
            break;
         end
      end
   endtask

   task automatic wait_dv_a(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (dv_a === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_a); end
      checks++; if (dout_a !== 128'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout_a); end
      checks++; if (dv_a !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b expected 0", dv_a); end
      checks++; if ({sclk_a, mosi_a, ce_a} !== 3'b000) begin errors++; $display("FAIL reset_spi: got sclk/mosi/ce %b expected 000", {sclk_a, mosi_a, ce_a}); end
      checks++; if (ready_b !== 1'b1 || ce_b !== 1'b0) begin errors++; $display("FAIL reset_b: got ready=%b ce=%b expected 1/0", ready_b, ce_b); end
`ifdef AES_SPI_HOST_TIMEOUT_EN
      checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_a); end
`endif
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_frame();
      int t0, t1, n0, v0;
      bit ok;
      logic [LA-1:0] exp;
      exp    = {8'h01, KEY192, CT192};
      dir_a  = DIR_DECRYPT;
      key_a  = KEY192;
      din_a  = CT192;
      resp_a = PT;
      done_a = 1'b0;
      n0 = ncap_a;
      v0 = nvalid_a;
      pulse_start_a(t0);
      checks++; if (ready_a !== 1'b0 || ce_a !== 1'b1) begin errors++; $display("FAIL frame_accept: got ready=%b ce=%b expected 0/1", ready_a, ce_a); end
      wait_ce_fall_a(t1, ok);
      checks++; if (!ok || (t1 - t0) != 2624) begin errors++; $display("FAIL frame_ce_fall: got %0d cycles (seen=%0d) expected 2624", t1 - t0, ok); end
      checks++; if ((ncap_a - n0) != 328) begin errors++; $display("FAIL frame_bits: got %0d expected 328", ncap_a - n0); end
      checks++; if (cap_a[LA-1:0] !== exp) begin errors++; $display("FAIL frame_mosi: got %h expected %h", cap_a[LA-1:0], exp); end
      repeat (5) @(negedge clk);
      done_a = 1'b1;
      wait_dv_a(ok);
      checks++; if (!ok || dout_a !== PT) begin errors++; $display("FAIL frame_dout: got %h (seen=%0d) expected %h", dout_a, ok, PT); end
      checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL frame_ready_during_valid: got %b expected 0", ready_a); end
      @(negedge clk);
      checks++; if (ready_a !== 1'b1 || dv_a !== 1'b0) begin errors++; $display("FAIL frame_ready_after: got ready=%b valid=%b expected 1/0", ready_a, dv_a); end
      done_a = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if ((nvalid_a - v0) != 1) begin errors++; $display("FAIL frame_valid_pulses: got %0d expected 1", nvalid_a - v0); end
   endtask

   task automatic test_done_early();
      int t0, te, tr;
      bit ok, seen;
      dir_a  = DIR_ENCRYPT;
      key_a  = KEY192;
      din_a  = PT;
      resp_a = RESP2;
      done_a = 1'b1;
      pulse_start_a(t0);
      wait_ce_fall_a(te, ok);
      seen = 1'b0;
      tr   = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (sclk_a === 1'b1) begin
            seen = 1'b1;
            tr   = cyc;
            break;
         end
      end
      // READ may not begin before 2 WAIT cycles, then SCLK is low for CLK_DIV
      checks++; if (!ok || !seen || (tr - te) < 6) begin errors++; $display("FAIL early_done_read_start: got %0d cycles (seen=%0d/%0d) expected >= 6", tr - te, ok, seen); end
      wait_dv_a(ok);
      checks++; if (!ok || dout_a !== RESP2) begin errors++; $display("FAIL early_done_dout: got %h expected %h", dout_a, RESP2); end
      done_a = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_start_spam();
      int t1, n0, f0;
      bit ok;
      logic [LA-1:0] exp;
      exp    = {8'h01, KEY192, CT192};
      dir_a  = DIR_DECRYPT;
      key_a  = KEY192;
      din_a  = CT192;
      resp_a = PT;
      n0 = ncap_a;
      f0 = nframe_a;
      @(negedge clk) start_a = 1'b1;
      @(negedge clk);
      dir_a = 8'hff;
      key_a = ~KEY192;
      din_a = ~CT192;
      wait_ce_fall_a(t1, ok);
      done_a = 1'b1;
      wait_dv_a(ok);
      checks++; if (!ok || dout_a !== PT) begin errors++; $display("FAIL spam_dout: got %h expected %h", dout_a, PT); end
      @(negedge clk);
      start_a = 1'b0;
      checks++; if (ready_a !== 1'b1 || ce_a !== 1'b0) begin errors++; $display("FAIL spam_start_with_valid: got ready=%b ce=%b expected 1/0", ready_a, ce_a); end
      done_a = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ((nframe_a - f0) != 1) begin errors++; $display("FAIL spam_frames: got %0d expected 1", nframe_a - f0); end
      checks++; if ((ncap_a - n0) != 328) begin errors++; $display("FAIL spam_bits: got %0d expected 328", ncap_a - n0); end
      checks++; if (cap_a[LA-1:0] !== exp) begin errors++; $display("FAIL spam_latched_frame: got %h expected %h", cap_a[LA-1:0], exp); end
      dir_a = DIR_DECRYPT;
      key_a = KEY192;
      din_a = CT192;
   endtask

   task automatic test_clkdiv1();
      int t0, t1, n0, viol;
      bit ok;
      logic prev;
      logic [LB-1:0] exp;
      exp    = {8'h00, KEY128, DINB};
      dir_b  = DIR_ENCRYPT;
      key_b  = KEY128;
      din_b  = DINB;
      resp_b = A5;
      n0   = ncap_b;
      viol = 0;
      ok   = 1'b0;
      t1   = 0;
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      t0   = cyc;
      prev = sclk_b;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (ce_b === 1'b0) begin
            ok = 1'b1;
            t1 = cyc;
            break;
         end
         if (sclk_b === prev) viol++;
         prev = sclk_b;
      end
      checks++; if (!ok || (t1 - t0) != 528) begin errors++; $display("FAIL div1_ce_fall: got %0d cycles (seen=%0d) expected 528", t1 - t0, ok); end
      checks++; if (viol != 0) begin errors++; $display("FAIL div1_sclk_toggle: got %0d stalled cycles expected 0", viol); end
      checks++; if ((ncap_b - n0) != 264) begin errors++; $display("FAIL div1_bits: got %0d expected 264", ncap_b - n0); end
      checks++; if (cap_b[LB-1:0] !== exp) begin errors++; $display("FAIL div1_mosi: got %h expected %h", cap_b[LB-1:0], exp); end
      done_b = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (dv_b === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++; if (!ok || dout_b !== A5) begin errors++; $display("FAIL div1_dout: got %h (seen=%0d) expected %h", dout_b, ok, A5); end
      done_b = 1'b0;
      repeat (3) @(negedge clk);
   endtask

`ifdef AES_SPI_HOST_TIMEOUT_EN
   task automatic test_timeout();
      int t0, te, ti, v0;
      bit ok, seen;
      done_a = 1'b0;
      v0 = nvalid_a;
      pulse_start_a(t0);
      wait_ce_fall_a(te, ok);
      seen = 1'b0;
      ti   = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ready_a === 1'b1) begin
            seen = 1'b1;
            ti   = cyc;
            break;
         end
      end
      checks++; if (!ok || !seen || (ti - te) != 16) begin errors++; $display("FAIL timeout_cycles: got %0d (seen=%0d/%0d) expected 16", ti - te, ok, seen); end
      checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL timeout_err_set: got %b expected 1", err_a); end
      checks++; if (dout_a !== PT || (nvalid_a - v0) != 0) begin errors++; $display("FAIL timeout_dout_kept: got %h valid=%0d expected %h valid=0", dout_a, nvalid_a - v0, PT); end
      pulse_start_a(t0);
      checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL timeout_err_clear: got %b expected 0", err_a); end
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask
`endif

   task automatic test_reset_mid_load();
      int t0, n0, v0;
      bit ok;
      dir_a = DIR_DECRYPT;
      key_a = KEY192;
      din_a = CT192;
      n0 = ncap_a;
      v0 = nvalid_a;
      pulse_start_a(t0);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ((ncap_a - n0) >= 50) begin
            ok = 1'b1;
            break;
         end
      end
      checks++; if (!ok || ce_a !== 1'b1) begin errors++; $display("FAIL midload_reached: got ce=%b bits=%0d expected 1/50", ce_a, ncap_a - n0); end
      reset = 1'b0;
      #1;
      checks++; if ({ce_a, sclk_a, mosi_a} !== 3'b000) begin errors++; $display("FAIL midload_spi_abort: got ce/sclk/mosi %b expected 000", {ce_a, sclk_a, mosi_a}); end
      checks++; if (ready_a !== 1'b1 || dv_a !== 1'b0) begin errors++; $display("FAIL midload_ready: got ready=%b valid=%b expected 1/0", ready_a, dv_a); end
      repeat (3) @(negedge clk);
      checks++; if ((nvalid_a - v0) != 0 || dout_a !== 128'h0) begin errors++; $display("FAIL midload_no_result: got valid=%0d dout=%h expected 0/0", nvalid_a - v0, dout_a); end
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_frame();
      test_done_early();
      test_start_spam();
      test_clkdiv1();
`ifdef AES_SPI_HOST_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_load();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
